// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the core/io clock-switch sequencer.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam logic CLK_SEL_CORE = 1'b0;
  localparam logic CLK_SEL_IO   = 1'b1;

  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_GATE_DELAY   = 4;
  localparam int unsigned DEF_SETTLE_DELAY = 8;
  localparam int unsigned DEF_IO_TIMEOUT   = 16;
  localparam int unsigned DEF_CNT_W        = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit; resets to 0.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_switch_sequencer.sv
// Sequences core/io clock-mux changes: gate, switch, settle, re-enable,
// with an io_clock activity watchdog that falls back to core_clock.
module clock_switch_sequencer
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned GATE_DELAY   = DEF_GATE_DELAY,
  parameter int unsigned SETTLE_DELAY = DEF_SETTLE_DELAY,
  parameter int unsigned IO_TIMEOUT   = DEF_IO_TIMEOUT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             core_clock,
  input  logic             core_rstn,
  input  logic             la_oenb,
  input  logic             io_clock,
  input  logic             fault_clr,
  output logic             clk_sel,
  output logic             clk_en,
  output logic             busy,
  output logic             io_alive,
  output logic             io_fault,
  output logic [CNT_W-1:0] switch_cnt
);

  localparam int unsigned DLY_MAX = max_u(GATE_DELAY, SETTLE_DELAY);
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
  localparam int unsigned ACT_W   = $clog2(IO_TIMEOUT + 1);

  logic req_s;
  logic io_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk   (core_clock),
    .rst_n (core_rstn),
    .d     (la_oenb),
    .q     (req_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_io (
    .clk   (core_clock),
    .rst_n (core_rstn),
    .d     (io_clock),
    .q     (io_s)
  );

  // io_clock activity monitor: cycles since the last synchronized edge.
  logic             io_prev_q,  io_prev_d;
  logic [ACT_W-1:0] act_cnt_q,  act_cnt_d;
  logic             io_alive_q, io_alive_d;
  logic             io_edge_c;

  always_comb begin
    io_edge_c  = (io_s != io_prev_q);
    io_prev_d  = io_s;
    act_cnt_d  = act_cnt_q;
    io_alive_d = (act_cnt_q < ACT_W'(IO_TIMEOUT));
    if (io_edge_c) begin
      act_cnt_d = '0;
    end else if (act_cnt_q < ACT_W'(IO_TIMEOUT)) begin
      act_cnt_d = act_cnt_q + ACT_W'(1);
    end
  end

  always_ff @(posedge core_clock or negedge core_rstn) begin
    if (!core_rstn) begin
      io_prev_q  <= 1'b0;
      act_cnt_q  <= '0;
      io_alive_q <= 1'b0;
    end else begin
      io_prev_q  <= io_prev_d;
      act_cnt_q  <= act_cnt_d;
      io_alive_q <= io_alive_d;
    end
  end

  // Switch sequencer state.
  state_e           state_q,      state_d;
  logic [DLY_W-1:0] cnt_q,        cnt_d;
  logic             target_q,     target_d;
  logic             clk_sel_q,    clk_sel_d;
  logic             clk_en_q,     clk_en_d;
  logic             busy_q,       busy_d;
  logic             io_fault_q,   io_fault_d;
  logic [CNT_W-1:0] switch_cnt_q, switch_cnt_d;
  logic             start_c;
  logic             fault_set_c;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    clk_sel_d    = clk_sel_q;
    clk_en_d     = clk_en_q;
    busy_d       = busy_q;
    switch_cnt_d = switch_cnt_q;
    start_c      = 1'b0;
    fault_set_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Dead io while running on it takes priority over any request.
        if (clk_sel_q == CLK_SEL_IO && !io_alive_q) begin
          start_c     = 1'b1;
          target_d    = CLK_SEL_CORE;
          fault_set_c = 1'b1;
        end else if (req_s && clk_sel_q == CLK_SEL_CORE) begin
          if (io_alive_q) begin
            start_c  = 1'b1;
            target_d = CLK_SEL_IO;
          end else begin
            fault_set_c = 1'b1;
          end
        end else if (!req_s && clk_sel_q == CLK_SEL_IO) begin
          start_c  = 1'b1;
          target_d = CLK_SEL_CORE;
        end
        if (start_c) begin
          state_d  = GATE;
          clk_en_d = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = DLY_W'(GATE_DELAY - 1);
        end
      end
      GATE: begin
        if (cnt_q == '0) begin
          state_d   = SWITCH;
          clk_sel_d = target_q;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      SWITCH: begin
        state_d = SETTLE;
        cnt_d   = DLY_W'(SETTLE_DELAY - 1);
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d      = IDLE;
          clk_en_d     = 1'b1;
          busy_d       = 1'b0;
          switch_cnt_d = switch_cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
    endcase

    // A new fault outranks a clear arriving in the same cycle.
    io_fault_d = fault_set_c | (io_fault_q & ~fault_clr);
  end

  always_ff @(posedge core_clock or negedge core_rstn) begin
    if (!core_rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      target_q     <= CLK_SEL_CORE;
      clk_sel_q    <= CLK_SEL_CORE;
      clk_en_q     <= 1'b1;
      busy_q       <= 1'b0;
      io_fault_q   <= 1'b0;
      switch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      clk_sel_q    <= clk_sel_d;
      clk_en_q     <= clk_en_d;
      busy_q       <= busy_d;
      io_fault_q   <= io_fault_d;
      switch_cnt_q <= switch_cnt_d;
    end
  end

  assign clk_sel    = clk_sel_q;
  assign clk_en     = clk_en_q;
  assign busy       = busy_q;
  assign io_alive   = io_alive_q;
  assign io_fault   = io_fault_q;
  assign switch_cnt = switch_cnt_q;

endmodule
